// File: rtl/fir_stream_pkg.sv
// Shared types and the round/saturate helper for the FIR output stream stage.
package fir_stream_pkg;

   typedef enum logic {S_WARMUP, S_RUN} decim_state_t;

   localparam int SAT_CNT_W = 16;

   typedef struct packed {
      logic        sat;
      logic [31:0] val;
   } sat_res_t;

   // x is the sign-extended input word; the sum cannot overflow 32 bits for inputs up to 31 bits wide.
   function automatic sat_res_t sat_round(input logic signed [31:0] x, input int shift, input int out_w);
      logic signed [31:0] t;
      logic signed [31:0] r;
      logic signed [31:0] lim_hi;
      logic signed [31:0] lim_lo;
      sat_res_t           res;
      t      = x + ((shift > 0) ? (32'sd1 <<< (shift - 1)) : 32'sd0);
      r      = t >>> shift;
      lim_hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      lim_lo = -(32'sd1 <<< (out_w - 1));
      res.sat = (r > lim_hi) || (r < lim_lo);
      if (r > lim_hi)
         res.val = lim_hi;
      else if (r < lim_lo)
         res.val = lim_lo;
      else
         res.val = r;
      return res;
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with registered pointers/level; a push while full is accepted if a pop happens in the same cycle.
module fir_sync_fifo #(
   parameter int DEPTH     = 8,
   parameter int OUT_WIDTH = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [OUT_WIDTH-1:0]       i_push_data,
   input  logic                       i_pop,
   output logic [OUT_WIDTH-1:0]       o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [OUT_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [LW-1:0]        r_level;
   logic                 w_push_ok;
   logic                 w_pop_ok;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/fir_output_decimator.sv
// FIR output warm-up discard, runtime decimation, round/saturate and output FIFO.
// Optional saturation event counter enabled by defining FIR_DECIM_SAT_CNT_EN.
//
// state    | meaning
// S_WARMUP | discarding delay-line fill transients
// S_RUN    | decimating; left only on reset
module fir_output_decimator
   import fir_stream_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 12,
   parameter int SHIFT     = 4,
   parameter int WARMUP    = 53,
   parameter int DECIM_MAX = 16,
   parameter int DEPTH     = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic signed [WIDTH-1:0]       in_data,
   input  logic [$clog2(DECIM_MAX):0]    decim_factor,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          out_data,
   output logic [$clog2(DEPTH):0]        fifo_level,
   output logic                          overflow,
   output logic [SAT_CNT_W-1:0]          sat_count
);

   localparam int PW = $clog2(DECIM_MAX) + 1;
   localparam int CW = $clog2(WARMUP);
   localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 2);
   localparam logic [PW-1:0] ONE       = PW'(1);

   decim_state_t          r_state;
   logic [CW-1:0]         r_warm_cnt;
   logic [PW-1:0]         r_ph;
   logic [PW-1:0]         r_d;
   logic [PW-1:0]         w_d_new;
   logic                  r_in_vld;
   logic signed [WIDTH-1:0] r_in_data;
   logic                  r_q_vld;
   logic [OUT_WIDTH-1:0]  r_q_data;
   logic                  r_overflow;
   sat_res_t              w_res;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_unused_bits;

   assign w_d_new = (decim_factor == '0) ? ONE : decim_factor;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_WARMUP;
         r_warm_cnt <= '0;
         r_ph       <= '0;
         r_d        <= ONE;
         r_in_vld   <= 1'b0;
         r_in_data  <= '0;
      end else begin
         r_in_vld <= 1'b0;
         if (in_valid) begin
            r_in_data <= in_data;
            case (r_state)
               S_WARMUP: begin
                  if (r_warm_cnt == WARM_LAST) begin
                     r_state <= S_RUN;
                     r_ph    <= '0;
                     r_d     <= w_d_new;
                  end else begin
                     r_warm_cnt <= r_warm_cnt + CW'(1);
                  end
               end
               S_RUN: begin
                  r_in_vld <= (r_ph == '0);
                  // New factor only takes effect at a period boundary.
                  if (r_ph == (r_d - ONE)) begin
                     r_ph <= '0;
                     r_d  <= w_d_new;
                  end else begin
                     r_ph <= r_ph + ONE;
                  end
               end
               default: r_state <= S_WARMUP;
            endcase
         end
      end
   end

   assign w_res = sat_round(32'(r_in_data), SHIFT, OUT_WIDTH);
   assign w_unused_bits = ^{w_res.val[31:OUT_WIDTH], w_res.sat};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q_vld    <= 1'b0;
         r_q_data   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_q_vld  <= r_in_vld;
         r_q_data <= w_res.val[OUT_WIDTH-1:0];
         if (r_q_vld && w_full && !w_pop)
            r_overflow <= 1'b1;
      end
   end

`ifdef FIR_DECIM_SAT_CNT_EN
   logic [SAT_CNT_W-1:0] r_sat_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_sat_cnt <= '0;
      else if (r_in_vld && w_res.sat && (r_sat_cnt != '1))
         r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
   end

   assign sat_count = r_sat_cnt;
`else
   assign sat_count = '0;
`endif

   assign w_pop     = !w_empty && out_ready;
   assign out_valid = !w_empty;
   assign overflow  = r_overflow;

   fir_sync_fifo #(
      .DEPTH     (DEPTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (r_q_vld),
      .i_push_data (r_q_data),
      .i_pop       (w_pop),
      .o_head      (out_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_level     (fifo_level)
   );

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed bench for fir_output_decimator with hand-computed expectations.
module tb_fir_output_decimator;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;
   logic [4:0]  decim_factor;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic [15:0] sat_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [11:0] q_out[$];

`ifdef FIR_DECIM_SAT_CNT_EN
   localparam int SAT_EXP = 1;
`else
   localparam int SAT_EXP = 0;
`endif

   fir_output_decimator dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .decim_factor (decim_factor),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .sat_count    (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Records every handshake just before the edge that performs it.
   task automatic step();
      if (out_valid && out_ready)
         q_out.push_back(out_data);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic warmup_check(input string tag);
      for (int i = 0; i < 52; i++)
         send(16'h0100);
      step();
      step();
      chk({tag, "_no_valid_52"}, 32'(out_valid), 0);
      send(16'h0100);
      step();
      chk({tag, "_no_valid_n1"}, 32'(out_valid), 0);
      step();
      chk({tag, "_valid_n2"}, 32'(out_valid), 1);
      chk({tag, "_data_n2"}, 32'(out_data), 32'h010);
   endtask

   task automatic send_expect(input string tag, input logic [15:0] d, input logic [11:0] exp);
      send(d);
      step();
      step();
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_data"}, 32'(out_data), 32'(exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_data      = '0;
      decim_factor = 5'd1;
      out_ready    = 1'b0;
      step();
      step();
      reset = 1'b0;

      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_sat_count", 32'(sat_count), 0);
      chk("rst_out_data", 32'(out_data), 0);

      // 1: warm-up discard and first kept sample latency
      warmup_check("t1");
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t1_level_after_pop", 32'(fifo_level), 0);

      // 2: round-half-up
      send_expect("t2_p24", 16'h0018, 12'h002);
      send_expect("t2_m24", 16'hFFE8, 12'hFFF);
      send_expect("t2_p7", 16'h0007, 12'h000);

      // 3: saturation
      send_expect("t3_max", 16'h7FFF, 12'h7FF);
      chk("t3_sat_cnt_max", 32'(sat_count), 32'(SAT_EXP));
      send_expect("t3_min", 16'h8000, 12'h800);
      chk("t3_sat_cnt_min", 32'(sat_count), 32'(SAT_EXP));

      // 4: D=4; one aligning input lets the new factor latch at the D=1 wrap
      out_ready    = 1'b1;
      decim_factor = 5'd4;
      send(16'h0000);
      step(); step(); step();
      q_out.delete();
      for (int k = 0; k < 16; k++)
         send(16'(k << 4));
      step(); step(); step(); step();
      chk("t4_count", 32'(q_out.size()), 4);
      for (int i = 0; i < 4 && i < q_out.size(); i++)
         chk($sformatf("t4_out%0d", i), 32'(q_out[i]), 32'(4 * i));

      // 5: overflow with factor 0 (treated as 1), latched after one D=4 period
      decim_factor = 5'd0;
      for (int i = 0; i < 4; i++)
         send(16'h0000);
      step(); step(); step();
      q_out.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++)
         send(16'((i + 1) << 4));
      step(); step();
      chk("t5_level_full", 32'(fifo_level), 8);
      chk("t5_overflow", 32'(overflow), 1);
      chk("t5_head_stable", 32'(out_data), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++)
         step();
      chk("t5_drain_count", 32'(q_out.size()), 8);
      for (int i = 0; i < 8 && i < q_out.size(); i++)
         chk($sformatf("t5_out%0d", i), 32'(q_out[i]), 32'(i + 1));
      chk("t5_level_empty", 32'(fifo_level), 0);
      chk("t5_overflow_sticky", 32'(overflow), 1);

      // 6: mid-operation reset
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         send(16'h0040);
      step(); step();
      chk("t6_level5", 32'(fifo_level), 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_out_valid", 32'(out_valid), 0);
      chk("t6_level", 32'(fifo_level), 0);
      chk("t6_overflow", 32'(overflow), 0);
      chk("t6_sat_count", 32'(sat_count), 0);
      warmup_check("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
